// File: rtl/vec_pkg.sv
// Shared types and defaults for the vector execute sequencer.
// Optional perf counters are enabled with `define VEC_SEQ_PERF_EN.
package vec_pkg;

    localparam int LANES_DEF    = 4;
    localparam int VLEN_DEF     = 16;
    localparam int MAX_WAIT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MEM  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_LD   = 2'b01;
    localparam logic [1:0] MEM_ST   = 2'b10;
    localparam logic [1:0] MEM_RSV  = 2'b11;

    typedef struct packed {
        logic       alu_st;
        logic       mem_st;
        logic       shift_op;
        logic [1:0] mem_op;
        logic [1:0] esc_wr;
        logic [1:0] vec_wr;
        logic [3:0] alu_op;
    } ctrl_word_t;

    // beat_idx stays at least one bit wide even for a single-beat vector.
    function automatic int beat_w(input int nbeats);
        return (nbeats > 1) ? $clog2(nbeats) : 1;
    endfunction

    localparam int BEAT_W_DEF = beat_w(VLEN_DEF / LANES_DEF);

endpackage

// File: rtl/vec_exec_seq_if.sv
// Control-word, memory-handshake and status bundle of the vector execute sequencer.
// perf_busy/perf_memwait exist only with `define VEC_SEQ_PERF_EN.
interface vec_exec_seq_if
    import vec_pkg::*;
#(
    parameter int BEAT_W = BEAT_W_DEF
);

    // Handshakes: a control word is taken on a rising clk edge where cl_valid=1 and
    // stall=0; while stall=1 upstream holds its register. mem_req stays high until the
    // edge where mem_ack=1 completes a beat, and may remain high into the next beat.
    logic             cl_valid;
    logic             cl_alu_st;
    logic             cl_mem_st;
    logic             cl_shift_op;
    logic [1:0]       cl_mem_op;
    logic [1:0]       cl_esc_wr;
    logic [1:0]       cl_vec_wr;
    logic [3:0]       cl_alu_op;
    logic             mem_ack;

    logic             stall;
    logic [BEAT_W-1:0] beat_idx;
    logic             alu_en;
    logic [3:0]       alu_op_o;
    logic             alu_st_o;
    logic             mem_st_o;
    logic             shift_o;
    logic             mem_req;
    logic             mem_we;
    logic             vec_wr_en;
    logic [1:0]       vec_wr_sel;
    logic             esc_wr_en;
    logic [1:0]       esc_wr_sel;
    logic             done;
    logic             err;
    seq_state_t       state_dbg;
`ifdef VEC_SEQ_PERF_EN
    logic [31:0]      perf_busy;
    logic [31:0]      perf_memwait;
`endif

    modport master (
`ifdef VEC_SEQ_PERF_EN
        input  perf_busy, perf_memwait,
`endif
        output cl_valid, cl_alu_st, cl_mem_st, cl_shift_op, cl_mem_op, cl_esc_wr,
               cl_vec_wr, cl_alu_op, mem_ack,
        input  stall, beat_idx, alu_en, alu_op_o, alu_st_o, mem_st_o, shift_o,
               mem_req, mem_we, vec_wr_en, vec_wr_sel, esc_wr_en, esc_wr_sel,
               done, err, state_dbg
    );

    modport slave (
`ifdef VEC_SEQ_PERF_EN
        output perf_busy, perf_memwait,
`endif
        input  cl_valid, cl_alu_st, cl_mem_st, cl_shift_op, cl_mem_op, cl_esc_wr,
               cl_vec_wr, cl_alu_op, mem_ack,
        output stall, beat_idx, alu_en, alu_op_o, alu_st_o, mem_st_o, shift_o,
               mem_req, mem_we, vec_wr_en, vec_wr_sel, esc_wr_en, esc_wr_sel,
               done, err, state_dbg
    );

endinterface

// File: rtl/vec_seq_timeout.sv
// Memory-ack wait counter: counts no-ack request cycles and flags the MAX_WAIT-th one.
module vec_seq_timeout #(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic wait_i,
    output logic expire_o
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt_q;

    assign expire_o = wait_i && (cnt_q == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (wait_i && !expire_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/vec_exec_seq.sv
// Vector execute sequencer: expands one latched control word into NBEATS ALU or memory beats.
// `define VEC_SEQ_PERF_EN adds saturating busy / memory-wait cycle counters.
module vec_exec_seq
    import vec_pkg::*;
#(
    parameter int LANES    = LANES_DEF,
    parameter int VLEN     = VLEN_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input logic           clk,
    input logic           rst_n,
    vec_exec_seq_if.slave bus
);

    localparam int NBEATS = VLEN / LANES;
    localparam int BEAT_W = beat_w(NBEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    seq_state_t        state_q;
    ctrl_word_t        ctrl_q;
    logic [BEAT_W-1:0] beat_q;
    logic              stall_q;
    logic              alu_en_q;
    logic              vec_wr_alu_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic              esc_wr_en_q;
    logic              done_q;
    logic              err_q;

    ctrl_word_t cl_word;
    logic       in_mem;
    logic       tmo_expire;
    logic       ld_wr;

    assign cl_word = '{alu_st:   bus.cl_alu_st,
                       mem_st:   bus.cl_mem_st,
                       shift_op: bus.cl_shift_op,
                       mem_op:   bus.cl_mem_op,
                       esc_wr:   bus.cl_esc_wr,
                       vec_wr:   bus.cl_vec_wr,
                       alu_op:   bus.cl_alu_op};

    assign in_mem = (state_q == MEM);
    // A load writes its element group in the cycle its data is acknowledged.
    assign ld_wr  = in_mem && bus.mem_ack && (ctrl_q.mem_op == MEM_LD) && (ctrl_q.vec_wr != 2'b00);

    vec_seq_timeout #(.MAX_WAIT(MAX_WAIT)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (!in_mem || bus.mem_ack),
        .wait_i   (in_mem && !bus.mem_ack),
        .expire_o (tmo_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ctrl_q       <= '0;
            beat_q       <= '0;
            stall_q      <= 1'b0;
            alu_en_q     <= 1'b0;
            vec_wr_alu_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            esc_wr_en_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            esc_wr_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cl_valid) begin
                        ctrl_q  <= cl_word;
                        err_q   <= 1'b0;
                        beat_q  <= '0;
                        stall_q <= 1'b1;
                        case (cl_word.mem_op)
                            MEM_NONE: begin
                                state_q      <= EXEC;
                                alu_en_q     <= 1'b1;
                                vec_wr_alu_q <= (cl_word.vec_wr != 2'b00);
                            end
                            MEM_LD, MEM_ST: begin
                                state_q   <= MEM;
                                mem_req_q <= 1'b1;
                                mem_we_q  <= (cl_word.mem_op == MEM_ST);
                            end
                            default: begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                                err_q   <= 1'b1;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    if (beat_q == LAST_BEAT) begin
                        state_q      <= DONE;
                        beat_q       <= '0;
                        alu_en_q     <= 1'b0;
                        vec_wr_alu_q <= 1'b0;
                        done_q       <= 1'b1;
                        esc_wr_en_q  <= (ctrl_q.esc_wr != 2'b00) && !err_q;
                    end else begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                MEM: begin
                    if (bus.mem_ack) begin
                        if (beat_q == LAST_BEAT) begin
                            state_q     <= DONE;
                            beat_q      <= '0;
                            mem_req_q   <= 1'b0;
                            mem_we_q    <= 1'b0;
                            done_q      <= 1'b1;
                            esc_wr_en_q <= (ctrl_q.esc_wr != 2'b00) && !err_q;
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end else if (tmo_expire) begin
                        state_q   <= DONE;
                        beat_q    <= '0;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    stall_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall      = stall_q;
    assign bus.beat_idx   = beat_q;
    assign bus.alu_en     = alu_en_q;
    assign bus.alu_op_o   = ctrl_q.alu_op;
    assign bus.alu_st_o   = ctrl_q.alu_st;
    assign bus.mem_st_o   = ctrl_q.mem_st;
    assign bus.shift_o    = ctrl_q.shift_op;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.vec_wr_en  = vec_wr_alu_q || ld_wr;
    assign bus.vec_wr_sel = ctrl_q.vec_wr;
    assign bus.esc_wr_en  = esc_wr_en_q;
    assign bus.esc_wr_sel = ctrl_q.esc_wr;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.state_dbg  = state_q;

`ifdef VEC_SEQ_PERF_EN
    logic [31:0] perf_busy_q;
    logic [31:0] perf_memwait_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_q    <= '0;
            perf_memwait_q <= '0;
        end else begin
            if (stall_q && !(&perf_busy_q)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if (in_mem && mem_req_q && !bus.mem_ack && !(&perf_memwait_q)) begin
                perf_memwait_q <= perf_memwait_q + 32'd1;
            end
        end
    end

    assign bus.perf_busy    = perf_busy_q;
    assign bus.perf_memwait = perf_memwait_q;
`endif

endmodule
